// File: rtl/cp0_unit_pkg.sv
// rtl/cp0_unit_pkg.sv - CP0 register numbers, exception codes and field positions
package cp0_unit_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_BD     = 31;

endpackage

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - CP0 exception/interrupt controller with SR, Cause, EPC and PRId
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_0701,
  parameter int          IM_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [4:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [31:0]     vpc,
  input  logic            bd_in,
  input  logic [4:0]      exc_code_in,
  input  logic [IM_W-1:0] hw_int,
  input  logic            eret,
  output logic            req,
  output logic [31:0]     epc_out
);

  logic [IM_W-1:0] sr_im;
  logic            sr_exl;
  logic            sr_ie;
  logic            cause_bd;
  logic [IM_W-1:0] cause_ip;
  logic [4:0]      cause_exc;
  logic [31:0]     epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] epc_src;

  assign int_req = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (exc_code_in != 5'd0) & ~sr_exl;
  assign req     = int_req | exc_req;

  // A faulting delay-slot instruction must restart at its branch.
  assign epc_src = bd_in ? (vpc - 32'd4) : vpc;

  assign epc_out = (en && addr == CP0_EPC) ? {wdata[31:2], 2'b00} : epc;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= 5'd0;
      epc       <= 32'd0;
    end else begin
      cause_ip <= hw_int;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bd_in;
        cause_exc <= int_req ? 5'd0 : exc_code_in;
        epc       <= {epc_src[31:2], 2'b00};
      end else begin
        if (en && addr == CP0_SR) begin
          sr_im  <= wdata[SR_IM_LO +: IM_W];
          sr_exl <= wdata[SR_EXL];
          sr_ie  <= wdata[SR_IE];
        end
        if (en && addr == CP0_EPC) epc <= wdata;
        // eret is applied last so it wins over a same-cycle SR write.
        if (eret) sr_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      CP0_SR: begin
        rdata[SR_IM_LO +: IM_W] = sr_im;
        rdata[SR_EXL]           = sr_exl;
        rdata[SR_IE]            = sr_ie;
      end
      CP0_CAUSE: begin
        rdata[CAUSE_BD]              = cause_bd;
        rdata[CAUSE_IP_LO +: IM_W]   = cause_ip;
        rdata[CAUSE_EXC_LO +: 5]     = cause_exc;
      end
      CP0_EPC:  rdata = epc;
      CP0_PRID: rdata = PRID;
      default:  rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - directed and randomized checks of cp0_unit against a word-level model
module tb_cp0_unit;
  import cp0_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, en, bd_in, eret;
  logic [4:0]  addr, exc_code_in;
  logic [31:0] wdata, vpc;
  logic [5:0]  hw_int;
  logic [31:0] rdata, epc_out;
  logic        req;

  int errors = 0;
  int checks = 0;

  // Model state kept as architectural register words.
  logic [31:0] m_sr, m_cause, m_epc;

  cp0_unit #(.PRID(32'h0000_0701), .IM_W(6)) dut (
    .clk(clk), .reset(reset), .en(en), .addr(addr), .wdata(wdata), .rdata(rdata),
    .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in), .hw_int(hw_int),
    .eret(eret), .req(req), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_int_req();
    return (|(hw_int & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int_req() || (exc_code_in != 5'd0 && !m_sr[1]);
  endfunction

  task automatic set_in(input logic r, input logic e, input logic [4:0] a, input logic [31:0] wd,
                        input logic [31:0] pc, input logic b, input logic [4:0] ec,
                        input logic [5:0] hw, input logic er);
    @(negedge clk);
    reset = r; en = e; addr = a; wdata = wd; vpc = pc; bd_in = b;
    exc_code_in = ec; hw_int = hw; eret = er;
    #1;
  endtask

  task automatic check_model();
    logic [31:0] exp_rd;
    case (addr)
      5'd12:   exp_rd = m_sr;
      5'd13:   exp_rd = m_cause;
      5'd14:   exp_rd = m_epc;
      5'd15:   exp_rd = 32'h0000_0701;
      default: exp_rd = 32'd0;
    endcase
    chk("req", {31'd0, req}, {31'd0, m_req()});
    chk("rdata", rdata, exp_rd);
    chk("epc_out", epc_out, (en && addr == 5'd14) ? (wdata & 32'hFFFF_FFFC) : m_epc);
  endtask

  task automatic tick();
    logic r, ir;
    r  = m_req();
    ir = m_int_req();
    @(posedge clk);
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause[15:10] = hw_int;
      if (r) begin
        m_sr[1]       = 1'b1;
        m_cause[31]   = bd_in;
        m_cause[6:2]  = ir ? 5'd0 : exc_code_in;
        m_epc         = (bd_in ? vpc - 32'd4 : vpc) & 32'hFFFF_FFFC;
      end else begin
        if (en && addr == 5'd12) m_sr = wdata & 32'h0000_FC03;
        if (en && addr == 5'd14) m_epc = wdata;
        if (eret) m_sr[1] = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [4:0] a, input logic [31:0] wd,
                      input logic [31:0] pc, input logic b, input logic [4:0] ec,
                      input logic [5:0] hw, input logic er);
    set_in(r, e, a, wd, pc, b, ec, hw, er);
    check_model();
    tick();
  endtask

  initial begin
    logic [4:0] codes [6];
    codes[0] = EXC_ADEL; codes[1] = EXC_ADES; codes[2] = EXC_SYSCALL;
    codes[3] = EXC_RI;   codes[4] = EXC_OV;   codes[5] = 5'd31;
    m_sr = 0; m_cause = 0; m_epc = 0;
    reset = 1; en = 0; addr = 0; wdata = 0; vpc = 0; bd_in = 0;
    exc_code_in = 0; hw_int = 0; eret = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    set_in(0, 0, CP0_PRID, 0, 0, 0, 0, 0, 0);
    check_model(); chk("prid", rdata, 32'h0000_0701); tick();
    set_in(0, 0, CP0_SR, 0, 0, 0, 0, 0, 0);
    check_model(); chk("sr_reset", rdata, 0); chk("req_reset", {31'd0, req}, 0);
    chk("epc_out_reset", epc_out, 0); tick();

    // Overflow outside a delay slot.
    set_in(0, 0, CP0_SR, 0, 32'h3010, 0, EXC_OV, 0, 0);
    check_model(); chk("ov_req", {31'd0, req}, 1); tick();
    set_in(0, 0, CP0_EPC, 0, 0, 0, 0, 0, 0);
    check_model(); chk("ov_epc", rdata, 32'h3010); chk("ov_req_drop", {31'd0, req}, 0); tick();
    set_in(0, 0, CP0_CAUSE, 0, 0, 0, 0, 0, 0);
    check_model(); chk("ov_cause", rdata, 32'h0000_0030); tick();
    set_in(0, 0, CP0_SR, 0, 0, 0, 0, 0, 0);
    check_model(); chk("ov_exl", rdata, 32'h2); tick();

    // Exception while EXL is set is masked.
    set_in(0, 0, CP0_SR, 0, 32'h5000, 0, EXC_ADEL, 0, 0);
    check_model(); chk("masked_req", {31'd0, req}, 0); tick();
    set_in(0, 0, CP0_EPC, 0, 0, 0, 0, 0, 0);
    check_model(); chk("masked_epc", rdata, 32'h3010); tick();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Delay-slot exception.
    set_in(0, 0, CP0_SR, 0, 32'h3024, 1, EXC_ADEL, 0, 0);
    check_model(); chk("bd_req", {31'd0, req}, 1); tick();
    set_in(0, 0, CP0_EPC, 0, 0, 0, 0, 0, 0);
    check_model(); chk("bd_epc", rdata, 32'h3020); tick();
    set_in(0, 0, CP0_CAUSE, 0, 0, 0, 0, 0, 0);
    check_model(); chk("bd_cause", rdata, 32'h8000_0010); tick();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Interrupt beats a simultaneous exception.
    step(0, 1, CP0_SR, 32'h0000_0401, 0, 0, 0, 0, 0);
    set_in(0, 0, CP0_CAUSE, 0, 32'h3040, 0, EXC_RI, 6'b000001, 0);
    check_model(); chk("int_req", {31'd0, req}, 1); tick();
    set_in(0, 0, CP0_CAUSE, 0, 0, 0, 0, 6'b000001, 0);
    check_model(); chk("int_cause", rdata, 32'h0000_0400); tick();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // mtc0 SR in the request cycle is dropped.
    set_in(0, 1, CP0_SR, 0, 32'h3050, 0, 0, 6'b000001, 0);
    check_model(); chk("sim_req", {31'd0, req}, 1); tick();
    set_in(0, 0, CP0_SR, 0, 0, 0, 0, 0, 0);
    check_model(); chk("sim_sr", rdata, 32'h0000_0403); tick();

    // EPC bypass and return.
    set_in(0, 1, CP0_EPC, 32'h3100, 0, 0, 0, 0, 0);
    check_model(); chk("byp_epc_out", epc_out, 32'h3100); tick();
    set_in(0, 0, CP0_SR, 0, 0, 0, 0, 0, 1);
    check_model(); chk("eret_epc_out", epc_out, 32'h3100); tick();
    set_in(0, 0, CP0_SR, 0, 0, 0, 0, 0, 0);
    check_model(); chk("eret_sr", rdata, 32'h0000_0401); tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] a;
      logic [4:0] ec;
      a  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
      ec = ($urandom_range(0, 4) == 0) ? codes[$urandom_range(0, 5)] : 5'd0;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), a, $urandom,
           $urandom, 1'($urandom), ec,
           ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0,
           ($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 exception/interrupt controller for the five-stage MIPS pipeline. It samples the M-stage exception summary (PC, branch-delay flag, accumulated exception code) and the external hardware interrupt lines. It raises the single-cycle flush request `req` that clears every pipeline register and redirects fetch to the handler, and holds the SR, Cause, EPC and PRId registers accessed by `mfc0`/`mtc0`/`eret`. It is the decision end of the `req` / `excCode` / `bd` path that the pipeline registers carry and obey.

## Interface
Parameters:
- `PRID`, default 32'h0000_0701: read-only processor ID value.
- `IM_W`, default 6: number of hardware interrupt lines.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `en`  in  1  `mtc0` write strobe from the M stage.
- `addr`  in  5  CP0 register number for read/write.
- `wdata`  in  32  `mtc0` write data.
- `rdata`  out  32  `mfc0` read data, combinational.
- `vpc`  in  32  PC of the instruction in M; bubbles carry their slot PC.
- `bd_in`  in  1  M instruction is in a branch delay slot.
- `exc_code_in`  in  5  M-stage exception code; 0 means none.
- `hw_int`  in  IM_W  external interrupt lines, level-sensitive.
- `eret`  in  1  `eret` is in M.
- `req`  out  1  flush and redirect to handler 0x0000_4180, combinational.
- `epc_out`  out  32  return address for `eret`.

## Operation
- Register map:
  - SR (12): IM[15:10], EXL[1], IE[0]. Other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]. Other bits read 0.
  - EPC (14): 32 bits.
  - PRId (15): `PRID`.
  - All other addresses read 0.
- Writable registers: only SR (masked to the defined fields) and EPC (full 32 bits). Writes to Cause, PRId and undefined addresses are ignored.
- Request logic:
  - `int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL`.
  - `exc_req = (exc_code_in != 0) & ~SR.EXL`.
  - `req = int_req | exc_req`.
  - Interrupt has priority over exception.
- On a clock edge where `req` is 1:
  - EXL <= 1.
  - BD <= `bd_in`.
  - ExcCode <= 0 if `int_req`, else `exc_code_in`.
  - EPC <= (`bd_in` ? `vpc - 4` : `vpc`) with bits [1:0] forced to 0.
  - The `mtc0` write and `eret` in the same cycle are suppressed.
- On a clock edge where `eret` is 1 and `req` is 0: EXL <= 0.
- Every cycle: Cause.IP <= `hw_int` (not affected by `req` or `mtc0`).
- `epc_out`:
  - equals `wdata[31:2],2'b00` when `en` and `addr == 14` in the same cycle (bypass for `mtc0 epc` immediately followed by `eret`);
  - otherwise equals EPC.
- `rdata` returns current register values. There is no bypass of a same-cycle write.
- ExcCode values used: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12. Any nonzero code is accepted verbatim.

## Timing
- Reset values: SR=0, Cause=0, EPC=0, so `req`=0, `rdata`=0 for all but PRId, `epc_out`=0. IP resumes sampling on the first cycle after reset.
- `req` is combinational in the cycle the condition holds. Register updates land on the next edge, so `req` deasserts the following cycle because EXL=1.
- `mtc0` takes effect at the edge and is visible on `rdata` the next cycle.
- Interrupt enable or IM changes via `mtc0` affect `req` from the next cycle.
- While EXL=1, both interrupts and exceptions are masked. Nested exceptions are not recorded.
- Reset asserted mid-handler clears EXL and EPC. Reset wins over `req`.

## Structure
- Shared package or `const.v`:
  - CP0 register numbers 12–15;
  - ExcCode constants;
  - handler address 32'h0000_4180;
  - SR/Cause field bit positions.
- Single flat module with no sub-module. The register file consists of three explicit registers plus a constant.

## Test plan
- Reset then read: reset 1 cycle, then read `addr`=15 -> `rdata`=32'h0000_0701; read `addr`=12 -> 0; `req`=0.
- Overflow: `exc_code_in`=12, `vpc`=0x3010, `bd_in`=0 -> `req`=1 that cycle; next cycle EPC=0x3010, ExcCode=12, EXL=1, `req`=0.
- Delay-slot exception: `exc_code_in`=4, `vpc`=0x3024, `bd_in`=1 -> EPC=0x3020, BD=1.
- Interrupt vs exception: SR written 0x0000_0401, `hw_int`=6'b000001, `exc_code_in`=10 the same cycle -> `req`=1, ExcCode=0, Cause.IP[10]=1.
- EPC bypass then return: `mtc0` EPC=0x3100 with `en`=1, `addr`=14 -> `epc_out`=0x3100 combinationally; a following `eret` cycle -> EXL=0.
- Masked and simultaneous events: exception with EXL=1 -> `req`=0 and EPC unchanged. `mtc0` SR with `wdata`=0 in the same cycle as `req` -> SR.IM is retained and EXL=1.
